// File: rtl/pkmc_wbarbiter_if.sv
// rtl/pkmc_wbarbiter_if.sv - Wishbone bus bundle between two masters, the arbiter and the memory controller
//
// Signals (names follow the arbiter's point of view):
//   mN_cyc_i, mN_stb_i, mN_we_i, mN_lock_i, mN_adr_i, mN_sel_i, mN_dat_i  master N request (N=0 CPU, N=1 DMA)
//   mN_dat_o, mN_ack_o, mN_err_o, mN_rty_o                                responses back to master N
//   s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_adr_o, s_sel_o, s_dat_o         request towards pkmc_wbmemctrl
//   s_dat_i, s_ack_i, s_err_i, s_rty_i                                    response from pkmc_wbmemctrl
// Modports:
//   master - the arbiter itself (it is the Wishbone master of the memory controller)
//   slave  - the environment: both requesting masters and the memory controller
interface pkmc_wbarbiter_if #(
    parameter int AW = 32
);
    logic          m0_cyc_i;
    logic          m0_stb_i;
    logic          m0_we_i;
    logic          m0_lock_i;
    logic [AW-1:0] m0_adr_i;
    logic [3:0]    m0_sel_i;
    logic [31:0]   m0_dat_i;
    logic [31:0]   m0_dat_o;
    logic          m0_ack_o;
    logic          m0_err_o;
    logic          m0_rty_o;

    logic          m1_cyc_i;
    logic          m1_stb_i;
    logic          m1_we_i;
    logic          m1_lock_i;
    logic [AW-1:0] m1_adr_i;
    logic [3:0]    m1_sel_i;
    logic [31:0]   m1_dat_i;
    logic [31:0]   m1_dat_o;
    logic          m1_ack_o;
    logic          m1_err_o;
    logic          m1_rty_o;

    logic          s_cyc_o;
    logic          s_stb_o;
    logic          s_we_o;
    logic          s_lock_o;
    logic [AW-1:0] s_adr_o;
    logic [3:0]    s_sel_o;
    logic [31:0]   s_dat_o;
    logic [31:0]   s_dat_i;
    logic          s_ack_i;
    logic          s_err_i;
    logic          s_rty_i;

    modport master (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i, m0_adr_i, m0_sel_i, m0_dat_i,
        output m0_dat_o, m0_ack_o, m0_err_o, m0_rty_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i, m1_adr_i, m1_sel_i, m1_dat_i,
        output m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_adr_o, s_sel_o, s_dat_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i
    );

    modport slave (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i, m0_adr_i, m0_sel_i, m0_dat_i,
        input  m0_dat_o, m0_ack_o, m0_err_o, m0_rty_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i, m1_adr_i, m1_sel_i, m1_dat_i,
        input  m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_adr_o, s_sel_o, s_dat_o,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i
    );
endinterface

// File: rtl/pkmc_wbarbiter.sv
// rtl/pkmc_wbarbiter.sv - two-master round-robin Wishbone arbiter in front of pkmc_wbmemctrl
//
// Parameters:
//   TIMEOUT - cycles without slave response before the watchdog aborts a cycle (2..255)
//   AW      - address width
// Ports:
//   wb_clk_i  - single clock, rising edge
//   wb_rst_ni - asynchronous active-low reset
//   bus       - pkmc_wbarbiter_if.master: both master ports and the memory controller port
// Optional feature:
//   PKMC_ARB_WATCHDOG_EN - when defined, builds the stall watchdog that answers a hung
//                          access with a one-cycle err to the granted master.
module pkmc_wbarbiter #(
    parameter int TIMEOUT = 255,
    parameter int AW      = 32
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    pkmc_wbarbiter_if.master       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   last_gnt_q;
    logic   gnt0;
    logic   gnt1;
    logic   wd_fire;

    // last_gnt only records who was granted; the state register alone drives the grant.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == GNT0) begin
                last_gnt_q <= 1'b0;
            end else if (state_q == IDLE && state_d == GNT1) begin
                last_gnt_q <= 1'b1;
            end
        end
    end

    // Grants always pass through IDLE, so a hand-over costs one dead cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    state_d = last_gnt_q ? GNT0 : GNT1;
                end else if (bus.m0_cyc_i) begin
                    state_d = GNT0;
                end else if (bus.m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!bus.m0_cyc_i && !bus.m0_lock_i) state_d = IDLE;
            end
            GNT1: begin
                if (!bus.m1_cyc_i && !bus.m1_lock_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

`ifdef PKMC_ARB_WATCHDOG_EN
    logic [7:0] wd_cnt_q;
    logic       gnt_stb;
    logic       slave_resp;

    assign gnt_stb    = (gnt0 && bus.m0_stb_i) || (gnt1 && bus.m1_stb_i);
    assign slave_resp = bus.s_ack_i || bus.s_err_i;
    // A response arriving in the very cycle the limit is hit still wins over the abort.
    assign wd_fire    = gnt_stb && !slave_resp && (wd_cnt_q == 8'(TIMEOUT));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wd_cnt_q <= 8'd0;
        end else if (wd_fire || !gnt_stb || slave_resp) begin
            wd_cnt_q <= 8'd0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT);
    assign wd_fire        = 1'b0;
`endif

    // Slave side is a plain mux of the granted master; everything reads 0 in IDLE.
    always_comb begin
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_we_o   = 1'b0;
        bus.s_lock_o = 1'b0;
        bus.s_adr_o  = '0;
        bus.s_sel_o  = 4'd0;
        bus.s_dat_o  = 32'd0;
        if (gnt0) begin
            bus.s_cyc_o  = bus.m0_cyc_i;
            bus.s_stb_o  = bus.m0_stb_i && !wd_fire;
            bus.s_we_o   = bus.m0_we_i;
            bus.s_lock_o = bus.m0_lock_i;
            bus.s_adr_o  = bus.m0_adr_i;
            bus.s_sel_o  = bus.m0_sel_i;
            bus.s_dat_o  = bus.m0_dat_i;
        end else if (gnt1) begin
            bus.s_cyc_o  = bus.m1_cyc_i;
            bus.s_stb_o  = bus.m1_stb_i && !wd_fire;
            bus.s_we_o   = bus.m1_we_i;
            bus.s_lock_o = bus.m1_lock_i;
            bus.s_adr_o  = bus.m1_adr_i;
            bus.s_sel_o  = bus.m1_sel_i;
            bus.s_dat_o  = bus.m1_dat_i;
        end
    end

    // Responses only reach the granted master, so a late ack seen in IDLE is dropped.
    always_comb begin
        bus.m0_dat_o = gnt0 ? bus.s_dat_i : 32'd0;
        bus.m0_ack_o = gnt0 && bus.s_ack_i;
        bus.m0_err_o = gnt0 && (bus.s_err_i || wd_fire);
        bus.m0_rty_o = gnt0 && bus.s_rty_i;
        bus.m1_dat_o = gnt1 ? bus.s_dat_i : 32'd0;
        bus.m1_ack_o = gnt1 && bus.s_ack_i;
        bus.m1_err_o = gnt1 && (bus.s_err_i || wd_fire);
        bus.m1_rty_o = gnt1 && bus.s_rty_i;
    end

endmodule

// File: tb/tb_pkmc_wbarbiter.sv
// tb/tb_pkmc_wbarbiter.sv - self-checking bench for pkmc_wbarbiter
module tb_pkmc_wbarbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pkmc_wbarbiter_if #(.AW(32)) bus();

    pkmc_wbarbiter #(.TIMEOUT(8), .AW(32)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    // Reference model: owner of the bus (-1 none) and last master granted.
    int mdl_gnt;
    int mdl_last;

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [141:0] all_outs();
        return {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_lock_o, bus.s_adr_o, bus.s_sel_o,
                bus.s_dat_o, bus.m0_dat_o, bus.m0_ack_o, bus.m0_err_o, bus.m0_rty_o,
                bus.m1_dat_o, bus.m1_ack_o, bus.m1_err_o, bus.m1_rty_o};
    endfunction

    task automatic drive_m(input int n, input logic cyc, input logic [31:0] adr,
                           input logic [31:0] dat, input logic we, input logic lock);
        if (n == 0) begin
            bus.m0_cyc_i = cyc; bus.m0_stb_i = cyc; bus.m0_adr_i = adr;
            bus.m0_dat_i = dat; bus.m0_we_i = we; bus.m0_sel_i = 4'hF; bus.m0_lock_i = lock;
        end else begin
            bus.m1_cyc_i = cyc; bus.m1_stb_i = cyc; bus.m1_adr_i = adr;
            bus.m1_dat_i = dat; bus.m1_we_i = we; bus.m1_sel_i = 4'hF; bus.m1_lock_i = lock;
        end
    endtask

    task automatic clear_inputs();
        drive_m(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive_m(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        bus.s_dat_i = 32'd0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        mdl_gnt  = -1;
        mdl_last = 1;
    endtask

    // Advance the model across the coming rising edge using the inputs now driven.
    task automatic mdl_step();
        logic c0, c1;
        c0 = bus.m0_cyc_i;
        c1 = bus.m1_cyc_i;
        if (mdl_gnt < 0) begin
            if (c0 && c1)  mdl_gnt = (mdl_last == 0) ? 1 : 0;
            else if (c0)   mdl_gnt = 0;
            else if (c1)   mdl_gnt = 1;
            if (mdl_gnt >= 0) mdl_last = mdl_gnt;
        end else if (mdl_gnt == 0) begin
            if (!c0 && !bus.m0_lock_i) mdl_gnt = -1;
        end else begin
            if (!c1 && !bus.m1_lock_i) mdl_gnt = -1;
        end
    endtask

    task automatic test_single_read();
        logic [31:0] rd;
        rd = $urandom;
        drive_m(0, 1'b1, 32'h0000_0100, 32'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL single_same_cycle: s_cyc_o=%b expected 0", bus.s_cyc_o); end
        tick();
        checks++;
        if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o} !== {3'b110, 32'h0000_0100}) begin
            failures++; $display("FAIL single_grant: cyc/stb/we/adr=%b%b%b %h expected 110 00000100",
                                 bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.m0_ack_o !== 1'b0) begin failures++; $display("FAIL single_wait_ack: m0_ack_o=%b expected 0", bus.m0_ack_o); end
        end
        bus.s_ack_i = 1'b1; bus.s_dat_i = rd;
        tick();
        checks++;
        if ({bus.m0_ack_o, bus.m0_dat_o} !== {1'b1, rd}) begin
            failures++; $display("FAIL single_ack: ack=%b dat=%h expected 1 %h", bus.m0_ack_o, bus.m0_dat_o, rd);
        end
        checks++;
        if ({bus.m1_ack_o, bus.m1_dat_o} !== 33'd0) begin
            failures++; $display("FAIL single_other_quiet: m1 ack=%b dat=%h expected 0 0", bus.m1_ack_o, bus.m1_dat_o);
        end
        drive_m(0, 1'b0, 32'h0000_0100, 32'd0, 1'b0, 1'b0);
        bus.s_ack_i = 1'b0;
        tick();
        checks++;
        if ({bus.s_cyc_o, bus.s_adr_o} !== 33'd0) begin
            failures++; $display("FAIL single_idle: cyc=%b adr=%h expected 0 0", bus.s_cyc_o, bus.s_adr_o);
        end
    endtask

    task automatic test_reset();
        logic [31:0] a0, a1;
        a0 = {8'h11, 24'($urandom)};
        a1 = {8'h22, 24'($urandom)};
        drive_m(0, 1'b1, a0, $urandom, 1'b1, 1'b0);
        drive_m(1, 1'b1, a1, $urandom, 1'b1, 1'b0);
        bus.s_ack_i = 1'b1; bus.s_err_i = 1'b1; bus.s_rty_i = 1'b1; bus.s_dat_i = $urandom;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin failures++; $display("FAIL reset_outputs: outs=%h expected 0", all_outs()); end
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (all_outs() !== '0) begin failures++; $display("FAIL reset_release: outs=%h expected 0", all_outs()); end
        tick();
        checks++;
        if ({bus.s_cyc_o, bus.s_adr_o, bus.m0_ack_o, bus.m1_ack_o} !== {1'b1, a0, 2'b10}) begin
            failures++; $display("FAIL reset_first_contest: cyc=%b adr=%h ack0=%b ack1=%b expected 1 %h 1 0",
                                 bus.s_cyc_o, bus.s_adr_o, bus.m0_ack_o, bus.m1_ack_o, a0);
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_round_robin();
        int          rem[2];
        logic [31:0] adr[2];
        int          seq[$];
        int          wait_n, guard, obs, obs_prev;
        logic        prev_scyc, exp_cyc, ack0, ack1, scyc, sstb;
        logic [31:0] exp_adr;
        do_reset();
        adr[0] = {8'h10, 22'($urandom), 2'b00};
        adr[1] = {8'h40, 22'($urandom), 2'b00};
        rem[0] = 4; rem[1] = 4;
        drive_m(0, 1'b1, adr[0], $urandom, 1'($urandom), 1'b0);
        drive_m(1, 1'b1, adr[1], $urandom, 1'($urandom), 1'b0);
        wait_n = $urandom_range(0, 2);
        prev_scyc = 1'b0; obs_prev = -1; guard = 0;
        mdl_step();
        while ((rem[0] > 0 || rem[1] > 0) && guard < 400) begin
            tick();
            guard++;
            exp_cyc = (mdl_gnt == 0) ? bus.m0_cyc_i : (mdl_gnt == 1) ? bus.m1_cyc_i : 1'b0;
            exp_adr = (mdl_gnt == 0) ? adr[0] : (mdl_gnt == 1) ? adr[1] : 32'd0;
            checks++;
            if ({bus.s_cyc_o, bus.s_adr_o} !== {exp_cyc, exp_adr}) begin
                failures++; $display("FAIL rr_slave_side: cyc=%b adr=%h expected %b %h", bus.s_cyc_o, bus.s_adr_o, exp_cyc, exp_adr);
            end
            checks++;
            if ({bus.m0_ack_o, bus.m0_dat_o, bus.m1_ack_o, bus.m1_dat_o} !==
                {(mdl_gnt == 0) && bus.s_ack_i, (mdl_gnt == 0) ? bus.s_dat_i : 32'd0,
                 (mdl_gnt == 1) && bus.s_ack_i, (mdl_gnt == 1) ? bus.s_dat_i : 32'd0}) begin
                failures++; $display("FAIL rr_response_route: ack0=%b ack1=%b dat0=%h dat1=%h owner=%0d s_ack=%b",
                                     bus.m0_ack_o, bus.m1_ack_o, bus.m0_dat_o, bus.m1_dat_o, mdl_gnt, bus.s_ack_i);
            end
            if (bus.s_cyc_o) begin
                obs = (bus.s_adr_o === adr[1]) ? 1 : 0;
                if (!prev_scyc) begin
                    seq.push_back(obs);
                end else begin
                    checks++;
                    if (obs != obs_prev) begin failures++; $display("FAIL rr_idle_gap: owner %0d follows %0d directly", obs, obs_prev); end
                end
                obs_prev = obs;
            end
            prev_scyc = bus.s_cyc_o;
            ack0 = bus.m0_ack_o; ack1 = bus.m1_ack_o; scyc = bus.s_cyc_o; sstb = bus.s_stb_o;
            if (bus.s_ack_i) begin
                bus.s_ack_i = 1'b0;
            end else if (scyc && sstb) begin
                if (wait_n == 0) begin
                    bus.s_ack_i = 1'b1; bus.s_dat_i = $urandom; wait_n = $urandom_range(0, 2);
                end else begin
                    wait_n--;
                end
            end
            if (ack0) begin rem[0]--; drive_m(0, 1'b0, adr[0], 32'd0, 1'b0, 1'b0); end
            else if (!bus.m0_cyc_i && rem[0] > 0) drive_m(0, 1'b1, adr[0], $urandom, 1'($urandom), 1'b0);
            if (ack1) begin rem[1]--; drive_m(1, 1'b0, adr[1], 32'd0, 1'b0, 1'b0); end
            else if (!bus.m1_cyc_i && rem[1] > 0) drive_m(1, 1'b1, adr[1], $urandom, 1'($urandom), 1'b0);
            mdl_step();
        end
        checks++;
        if (rem[0] != 0 || rem[1] != 0) begin failures++; $display("FAIL rr_timeout: remaining %0d/%0d expected 0/0", rem[0], rem[1]); end
        checks++;
        if (seq.size() != 8) begin failures++; $display("FAIL rr_grant_count: got %0d expected 8", seq.size()); end
        for (int i = 0; i < seq.size(); i++) begin
            checks++;
            if (seq[i] != i % 2) begin failures++; $display("FAIL rr_order: grant %0d went to m%0d expected m%0d", i, seq[i], i % 2); end
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_lock();
        logic [31:0] d1, d2, a0;
        d1 = $urandom; d2 = $urandom; a0 = {8'h12, 24'($urandom)};
        do_reset();
        drive_m(1, 1'b1, 32'h0400_0000, d1, 1'b1, 1'b1);
        tick();
        checks++;
        if ({bus.s_cyc_o, bus.s_we_o, bus.s_lock_o, bus.s_adr_o, bus.s_dat_o} !== {3'b111, 32'h0400_0000, d1}) begin
            failures++; $display("FAIL lock_first_write: cyc/we/lock=%b%b%b adr=%h dat=%h expected 111 04000000 %h",
                                 bus.s_cyc_o, bus.s_we_o, bus.s_lock_o, bus.s_adr_o, bus.s_dat_o, d1);
        end
        drive_m(0, 1'b1, a0, 32'd0, 1'b0, 1'b0);
        bus.s_ack_i = 1'b1;
        tick();
        checks++;
        if ({bus.m1_ack_o, bus.m0_ack_o} !== 2'b10) begin
            failures++; $display("FAIL lock_ack1: ack1=%b ack0=%b expected 1 0", bus.m1_ack_o, bus.m0_ack_o);
        end
        drive_m(1, 1'b0, 32'h0400_0000, d1, 1'b1, 1'b1);
        bus.s_ack_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus.s_cyc_o, bus.s_lock_o, bus.s_adr_o} !== {2'b01, 32'h0400_0000}) begin
                failures++; $display("FAIL lock_gap: cyc=%b lock=%b adr=%h expected 0 1 04000000", bus.s_cyc_o, bus.s_lock_o, bus.s_adr_o);
            end
        end
        drive_m(1, 1'b1, 32'h0400_0004, d2, 1'b1, 1'b1);
        tick();
        checks++;
        if ({bus.s_cyc_o, bus.s_adr_o, bus.s_dat_o} !== {1'b1, 32'h0400_0004, d2}) begin
            failures++; $display("FAIL lock_second_write: cyc=%b adr=%h dat=%h expected 1 04000004 %h", bus.s_cyc_o, bus.s_adr_o, bus.s_dat_o, d2);
        end
        bus.s_ack_i = 1'b1;
        tick();
        checks++;
        if (bus.m1_ack_o !== 1'b1) begin failures++; $display("FAIL lock_ack2: ack1=%b expected 1", bus.m1_ack_o); end
        drive_m(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        bus.s_ack_i = 1'b0;
        tick();
        checks++;
        if ({bus.s_cyc_o, bus.s_adr_o} !== 33'd0) begin
            failures++; $display("FAIL lock_release_idle: cyc=%b adr=%h expected 0 0", bus.s_cyc_o, bus.s_adr_o);
        end
        tick();
        checks++;
        if ({bus.s_cyc_o, bus.s_adr_o} !== {1'b1, a0}) begin
            failures++; $display("FAIL lock_m0_granted: cyc=%b adr=%h expected 1 %h", bus.s_cyc_o, bus.s_adr_o, a0);
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        drive_m(0, 1'b1, 32'h0000_0200, 32'd0, 1'b0, 1'b0);
        tick();
`ifdef PKMC_ARB_WATCHDOG_EN
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({bus.m0_err_o, bus.s_stb_o} !== ((k == 8) ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL watchdog_cycle_%0d: err=%b stb=%b expected %b", k, bus.m0_err_o, bus.s_stb_o,
                                     (k == 8) ? 2'b10 : 2'b01);
            end
            tick();
        end
`else
        for (int k = 0; k < 20; k++) begin
            checks++;
            if ({bus.m0_err_o, bus.s_stb_o} !== 2'b01) begin
                failures++; $display("FAIL hang_cycle_%0d: err=%b stb=%b expected 0 1", k, bus.m0_err_o, bus.s_stb_o);
            end
            tick();
        end
`endif
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] a0, a1;
        a0 = {8'h13, 24'($urandom)};
        a1 = {8'h23, 24'($urandom)};
        do_reset();
        drive_m(1, 1'b1, a1, $urandom, 1'b0, 1'b0);
        tick();
        checks++;
        if ({bus.s_cyc_o, bus.s_adr_o} !== {1'b1, a1}) begin
            failures++; $display("FAIL midreset_grant1: cyc=%b adr=%h expected 1 %h", bus.s_cyc_o, bus.s_adr_o, a1);
        end
        bus.s_ack_i = 1'b1; bus.s_err_i = 1'b1; bus.s_rty_i = 1'b1; bus.s_dat_i = $urandom | 32'h1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin failures++; $display("FAIL midreset_outputs: outs=%h expected 0", all_outs()); end
        tick();
        rst_n = 1'b1;
        bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
        drive_m(0, 1'b1, a0, $urandom, 1'b0, 1'b0);
        tick();
        checks++;
        if ({bus.s_cyc_o, bus.s_adr_o} !== {1'b1, a0}) begin
            failures++; $display("FAIL midreset_contest: cyc=%b adr=%h expected 1 %h", bus.s_cyc_o, bus.s_adr_o, a0);
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_early_drop();
        do_reset();
        drive_m(0, 1'b1, 32'h0000_0300, 32'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.s_cyc_o !== 1'b1) begin failures++; $display("FAIL drop_grant: cyc=%b expected 1", bus.s_cyc_o); end
        drive_m(0, 1'b0, 32'h0000_0300, 32'd0, 1'b0, 1'b0);
        bus.s_ack_i = 1'b1; bus.s_dat_i = $urandom | 32'h1;
        tick();
        checks++;
        if ({bus.s_cyc_o, bus.m0_ack_o, bus.m0_dat_o, bus.m1_ack_o, bus.m1_dat_o} !== 67'd0) begin
            failures++; $display("FAIL drop_late_ack: cyc=%b ack0=%b dat0=%h ack1=%b dat1=%h expected all 0",
                                 bus.s_cyc_o, bus.m0_ack_o, bus.m0_dat_o, bus.m1_ack_o, bus.m1_dat_o);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        do_reset();
        test_single_read();
        test_reset();
        test_round_robin();
        test_lock();
        test_watchdog();
        test_reset_mid_access();
        test_early_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
